// File: rtl/riscv_trace_monitor.sv
// Execution monitor for riscv_top: records every PC change into a circular
// trace buffer and flags end-of-program pass/fail, PC hangs and cycle timeouts.
module riscv_trace_monitor #(
  parameter int              XLEN           = 32,
  parameter int              DEPTH          = 16,
  parameter int              HANG_LIMIT     = 64,
  parameter int              TIMEOUT_CYCLES = 10000,
  parameter logic [XLEN-1:0] END_PC         = 'h40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       wrap_mode,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            result,
  input  logic [XLEN-1:0]            expected,
  input  logic                       rd_en,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_result,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       hang,
  output logic                       timeout,
  output logic                       done,
  output logic                       pass,
  output logic [31:0]                cycle_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(HANG_LIMIT+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d, rd_result_q, rd_result_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d, hang_q, hang_d, timeout_q, timeout_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [31:0]     cycle_q, cycle_d;
  logic            mem_we, active, sample, pop, full, empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_pc_d   = last_pc_q;
    rd_pc_d     = rd_pc_q;
    rd_result_d = rd_result_q;
    overflow_d  = overflow_q;
    hang_d      = hang_q;
    timeout_d   = timeout_q;
    done_d      = done_q;
    pass_d      = pass_q;
    stall_d     = stall_q;
    cycle_d     = cycle_q;
    mem_we      = 1'b0;

    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    active = enable && !done_q;
    sample = active && (pc != last_pc_q);
    pop    = rd_en && !empty;
    rd_valid_d = pop;

    if (pop) begin
      rd_pc_d     = mem_q[rd_ptr_q].pc;
      rd_result_d = mem_q[rd_ptr_q].result;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end

    if (sample) begin
      last_pc_d = pc;
      // A concurrent pop frees the oldest slot, so a full buffer still accepts.
      if (!full || pop) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (wrap_mode) begin
        mem_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
      if (pc == END_PC) begin
        done_d = 1'b1;
        pass_d = (result == expected);
      end
    end

    if (mem_we && !pop && !full) count_d = count_q + 1'b1;
    else if (pop && !mem_we)     count_d = count_q - 1'b1;

    if (active) begin
      if (sample) stall_d = '0;
      else begin
        if (stall_q != SW'(HANG_LIMIT)) stall_d = stall_q + 1'b1;
        if (stall_d == SW'(HANG_LIMIT)) hang_d = 1'b1;
      end
      if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
      if (cycle_d == 32'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= '1;
      rd_pc_q     <= '0;
      rd_result_q <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      hang_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      stall_q     <= '0;
      cycle_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= last_pc_d;
      rd_pc_q     <= rd_pc_d;
      rd_result_q <= rd_result_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      hang_q      <= hang_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      stall_q     <= stall_d;
      cycle_q     <= cycle_d;
    end
  end

  // Trace storage needs no reset; contents are only read behind count.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= '{pc: pc, result: result};
  end

  assign rd_pc     = rd_pc_q;
  assign rd_result = rd_result_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign hang      = hang_q;
  assign timeout   = timeout_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign cycle_cnt = cycle_q;
endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Scoreboard bench for riscv_trace_monitor: a reference queue holds the
// expected trace contents; every pop is compared with its front entry.
module tb_riscv_trace_monitor;
  logic        clk = 1'b0;
  logic        reset, enable, wrap_mode, rd_en;
  logic [31:0] pc, result, expected;
  logic [31:0] rd_pc, rd_result, cycle_cnt;
  logic        rd_valid, overflow, hang, timeout, done, pass;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  riscv_trace_monitor #(.XLEN(32), .DEPTH(4), .HANG_LIMIT(8), .TIMEOUT_CYCLES(100),
                        .END_PC(32'h40)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wrap_mode(wrap_mode), .pc(pc),
    .result(result), .expected(expected), .rd_en(rd_en), .rd_pc(rd_pc),
    .rd_result(rd_result), .rd_valid(rd_valid), .count(count), .overflow(overflow),
    .hang(hang), .timeout(timeout), .done(done), .pass(pass), .cycle_cnt(cycle_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; rd_en = 1'b0; wrap_mode = 1'b1;
    pc = '0; result = '0; expected = '0;
    tick();
    reset = 1'b1;
    sb.delete();
  endtask

  // Present one distinct PC for a cycle; the model follows wrap/drop rules.
  task automatic sample(input logic [31:0] p, input logic [31:0] r);
    pc = p; result = r;
    if (sb.size() < 4) sb.push_back({p, r});
    else if (wrap_mode) begin
      void'(sb.pop_front());
      sb.push_back({p, r});
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; rd_en = 1'b0; wrap_mode = 1'b0;
    pc = '0; result = '0; expected = '0;
    tick(); tick();
    n_cmp++;
    if ({rd_pc, rd_result, rd_valid, count, overflow, hang, timeout, done, pass, cycle_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h res=%h v=%b cnt=%0d ov=%b h=%b to=%b d=%b p=%b cyc=%0d, want all 0",
               rd_pc, rd_result, rd_valid, count, overflow, hang, timeout, done, pass, cycle_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] e;
    do_reset();
    enable = 1'b1;
    sample(32'h0, 32'h11); sample(32'h4, 32'h22); sample(32'h8, 32'h33);
    n_cmp++;
    if (count !== 3'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", count); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; e = sb.pop_front();
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || {rd_pc, rd_result} !== e) begin
        n_err++;
        $display("FAIL basic_pop%0d: got v=%b %h/%h want 1 %h/%h", i, rd_valid, rd_pc, rd_result, e[63:32], e[31:0]);
      end
    end
    rd_en = 1'b1;
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_pc !== 32'h8 || rd_result !== 32'h33) begin
      n_err++;
      $display("FAIL empty_pop: got v=%b %h/%h want 0 00000008/00000033", rd_valid, rd_pc, rd_result);
    end
    rd_en = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL basic_end: got cnt=%0d ov=%b want 0 0", count, overflow);
    end
  endtask

  task automatic test_wrap_drop();
    logic [63:0] e;
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      wrap_mode = m[0]; enable = 1'b1;
      for (int i = 0; i < 6; i++) sample(32'(i * 4), 32'h100 + 32'(i));
      enable = 1'b0;
      n_cmp++;
      if (count !== 3'd4 || overflow !== 1'b1) begin
        n_err++; $display("FAIL wrap%0d_full: got cnt=%0d ov=%b want 4 1", m, count, overflow);
      end
      for (int i = 0; i < 4; i++) begin
        rd_en = 1'b1; e = sb.pop_front();
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || {rd_pc, rd_result} !== e) begin
          n_err++;
          $display("FAIL wrap%0d_pop%0d: got v=%b %h/%h want 1 %h/%h", m, i, rd_valid, rd_pc, rd_result, e[63:32], e[31:0]);
        end
        if (i == 0) begin
          n_cmp++;
          if (rd_pc !== (m ? 32'h8 : 32'h0)) begin
            n_err++; $display("FAIL wrap%0d_oldest: got %h want %h", m, rd_pc, (m ? 32'h8 : 32'h0));
          end
        end
      end
      rd_en = 1'b0;
    end
  endtask

  task automatic test_hang();
    do_reset();
    enable = 1'b1;
    sample(32'h8, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (hang !== 1'b0) begin n_err++; $display("FAIL hang_7: got %b want 0", hang); end
    tick();
    n_cmp++;
    if (hang !== 1'b1) begin n_err++; $display("FAIL hang_8: got %b want 1", hang); end
    sample(32'hC, 32'h0);
    n_cmp++;
    if (hang !== 1'b1) begin n_err++; $display("FAIL hang_sticky: got %b want 1", hang); end
    enable = 1'b0;
  endtask

  task automatic test_end_pass();
    logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      expected = k ? 32'hBEEF : 32'hDEAD;
      enable = 1'b1;
      sample(32'h0, 32'h1); sample(32'h4, 32'h2); sample(32'h40, 32'hDEAD);
      n_cmp++;
      if (done !== 1'b1 || pass !== (k == 0) || cycle_cnt !== 32'd3) begin
        n_err++;
        $display("FAIL end%0d: got d=%b p=%b cyc=%0d want 1 %b 3", k, done, pass, cycle_cnt, (k == 0));
      end
      pc = 32'h44; tick(); pc = 32'h48; tick();
      n_cmp++;
      if (count !== 3'd3 || cycle_cnt !== 32'd3 || done !== 1'b1 || pass !== (k == 0)) begin
        n_err++;
        $display("FAIL end%0d_frozen: got cnt=%0d cyc=%0d d=%b p=%b want 3 3 1 %b", k, count, cycle_cnt, done, pass, (k == 0));
      end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
        rd_en = 1'b1; e = sb.pop_front();
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || {rd_pc, rd_result} !== e) begin
          n_err++;
          $display("FAIL end%0d_pop%0d: got %h/%h want %h/%h", k, i, rd_pc, rd_result, e[63:32], e[31:0]);
        end
      end
      rd_en = 1'b0;
    end
  endtask

  task automatic test_timeout_full_push_pop();
    logic [63:0] e;
    do_reset();
    wrap_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) sample(32'h100 + 32'(i * 4), 32'(i));
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_err++; $display("FAIL tmo_fill: got cnt=%0d ov=%b want 4 0", count, overflow);
    end
    for (int c = 5; c <= 100; c++) begin
      rd_en = 1'b1;
      e = sb.pop_front();
      sb.push_back({32'h100 + 32'((c - 1) * 4), 32'(c - 1)});
      pc = 32'h100 + 32'((c - 1) * 4); result = 32'(c - 1);
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || {rd_pc, rd_result} !== e || count !== 3'd4 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL full_pushpop%0d: got v=%b %h/%h cnt=%0d ov=%b want 1 %h/%h 4 0",
                 c, rd_valid, rd_pc, rd_result, count, overflow, e[63:32], e[31:0]);
      end
      if (c >= 99) begin
        n_cmp++;
        if (timeout !== (c == 100) || cycle_cnt !== 32'(c)) begin
          n_err++; $display("FAIL timeout_c%0d: got to=%b cyc=%0d want %b %0d", c, timeout, cycle_cnt, (c == 100), c);
        end
      end
    end
    rd_en = 1'b0;
    pc = 32'h1000; tick();
    n_cmp++;
    if (timeout !== 1'b1 || cycle_cnt !== 32'd101) begin
      n_err++; $display("FAIL timeout_sticky: got to=%b cyc=%0d want 1 101", timeout, cycle_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] e;
    do_reset();
    enable = 1'b1;
    sample(32'h0, 32'h1); sample(32'h4, 32'h2); sample(32'h8, 32'h3);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (count !== 3'd2 || hang !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_pre: got cnt=%0d h=%b v=%b want 2 1 0", count, hang, rd_valid);
    end
    rd_en = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({rd_pc, rd_result, rd_valid, count, overflow, hang, timeout, done, pass, cycle_cnt} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async: got pc=%h res=%h v=%b cnt=%0d h=%b cyc=%0d want all 0",
               rd_pc, rd_result, rd_valid, count, hang, cycle_cnt);
    end
    rd_en = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    sample(32'h8, 32'h77);
    enable = 1'b0;
    n_cmp++;
    if (count !== 3'd1) begin n_err++; $display("FAIL mid_first: got cnt=%0d want 1", count); end
    rd_en = 1'b1; e = sb.pop_front();
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || {rd_pc, rd_result} !== e) begin
      n_err++; $display("FAIL mid_pop: got %h/%h want %h/%h", rd_pc, rd_result, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_drop();
    test_hang();
    test_end_pass();
    test_timeout_full_push_pop();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
